serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Sequencer that drives a single 1-bit adder slice, built from two half-adder cells and one carry flop, to add two WIDTH-bit operands bit-serially, LSB first, one bit per clock. It trades WIDTH cycles of latency for one adder slice. It sits between a requester, using a start/busy/done handshake, and the half-adder datapath, and owns the operand shift registers, bit counter, carry register and result register.

## Interface
- WIDTH, 8, operand and result width; legal range 2..32
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- op_a  in  WIDTH  augend, captured on accepted start
- op_b  in  WIDTH  addend, captured on accepted start
- busy  out  1  high while state is RUN
- done  out  1  one-cycle pulse, state DONE
- result  out  WIDTH  sum; held from the last RUN edge until the next completed operation
- carry_out  out  1  final carry; held like result

## Operation
- One clock (clk); reset is asynchronous and active-high (rst).
- Reset values:
  - state IDLE; busy 0; done 0; result 0; carry_out 0
  - internal shift registers, carry and bit counter all 0
- Datapath per bit:
  - s1 = a^b, c1 = a&b (half adder 1)
  - sum = s1^cin, c2 = s1&cin (half adder 2)
  - cout = c1|c2
- FSM states: IDLE, RUN, DONE.
  - IDLE:
    - start=1 captures op_a/op_b into shift regs, clears the carry, sets the counter to 0, and moves to RUN.
    - start=0 stays in IDLE.
  - RUN, on each edge:
    - The slice consumes bit 0 of both shift regs.
    - Both operand regs shift right.
    - sum shifts into the result shift reg at the MSB.
    - carry <= cout; counter increments.
    - When the counter reaches WIDTH-1 on this edge, transfer the shifted result to result, cout to carry_out, and go to DONE.
  - DONE: done=1 for exactly one cycle, then unconditionally IDLE.
- start in RUN or DONE is ignored: no queuing, and operands are not re-captured.
- The counter is $clog2(WIDTH) bits wide and never wraps past WIDTH-1.
- Arithmetic: result = (op_a + op_b) mod 2^WIDTH; carry_out = bit WIDTH of the true sum.
- The result output is unchanged during RUN. It updates only on the final RUN edge.

## Timing
- Edge E0: start accepted; busy=1 after E0.
- Edges E1..EWIDTH process bits 0..WIDTH-1.
  - result and carry_out are valid after EWIDTH.
  - busy falls and done rises after EWIDTH.
- done falls after EWIDTH+1, and the state returns to IDLE.
- A new start is accepted at EWIDTH+2 at the earliest.
- Start-to-done latency is WIDTH cycles; issue interval is WIDTH+2 cycles.
- rst asserted at any point, including mid-RUN: all outputs go to reset values immediately (asynchronously), and the partial result is discarded.
- rst deasserted with start=1: start is sampled on the first clk edge after release.

## Configuration
- SERIAL_ADD_SUB_EN defined: adds input `sub` (1 bit), sampled with the operands at start.
  - sub=1: the captured op_b is inverted and the carry is initialised to 1, giving result = (op_a - op_b) mod 2^WIDTH.
  - carry_out = 1 means no borrow (op_a ≥ op_b).
  - sub=0 behaves exactly as without the macro.
- SERIAL_ADD_SUB_EN undefined: no `sub` port; add only; carry is initialised to 0.

## Test plan
- WIDTH=8: reset, then start with op_a=0x00, op_b=0x00 -> done pulses exactly 8 cycles after the start edge; result=0x00, carry_out=0; busy high for exactly 8 cycles.
- op_a=0xFF, op_b=0x01 -> result=0x00, carry_out=1; result stays at its old value until the final RUN edge.
- op_a=0xA5, op_b=0x5A, then start held high through busy with op_a=0x11, op_b=0x22 presented -> first result=0xFF, carry_out=0. The held start then launches a second op at EWIDTH+2, giving result=0x33.
- Start 0xF0+0x0F, assert rst for 1 cycle at the 4th RUN edge -> immediate busy=0, done=0, result=0x00, carry_out=0. No done pulse follows, and the next start runs normally.
- SERIAL_ADD_SUB_EN defined:
  - sub=1, 0x07-0x05 -> result=0x02, carry_out=1
  - sub=1, 0x05-0x07 -> result=0xFE, carry_out=0
  - sub=0, 0x05+0x07 -> result=0x0C, carry_out=0

Source files
------------

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial WIDTH-bit adder sequencer around one 1-bit slice
// (two half-adder cells plus a carry flop), LSB first, one bit per clock.
// Optional feature macro: SERIAL_ADD_SUB_EN adds a 'sub' input that turns the
// operation into op_a - op_b (two's complement: inverted op_b, carry-in 1).

// Half-adder cell; two of these plus an OR form the full-adder slice.
module serial_add_ha (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state, nstate;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh;
  logic             cin;
  logic [CW-1:0]    cnt;
  logic             last;

  // slice signals
  logic s1, c1, sum, c2, cout;

  // values loaded into the operand regs / carry on an accepted start
  logic [WIDTH-1:0] b_cap;
  logic             cin_cap;

`ifdef SERIAL_ADD_SUB_EN
  // Subtract = add the one's complement of op_b with carry-in 1.
  always_comb begin
    b_cap   = sub ? ~op_b : op_b;
    cin_cap = sub;
  end
`else
  // Add only: operands pass straight through, carry starts clear.
  always_comb begin
    b_cap   = op_b;
    cin_cap = 1'b0;
  end
`endif

  serial_add_ha u_ha1 (.a(a_sh[0]), .b(b_sh[0]), .s(s1),  .c(c1));
  serial_add_ha u_ha2 (.a(s1),      .b(cin),     .s(sum), .c(c2));
  assign cout = c1 | c2;

  // Bit counter holds at WIDTH-1 on the final RUN edge instead of wrapping.
  assign last = (cnt == LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nstate;
  end

  // Next-state logic; start is only looked at in IDLE
  always_comb begin
    nstate = state;
    case (state)
      S_IDLE:  if (start) nstate = S_RUN;
      S_RUN:   if (last)  nstate = S_DONE;
      S_DONE:  nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  // Status outputs decoded straight from state so reset clears them at once
  always_comb begin
    busy = (state == S_RUN);
    done = (state == S_DONE);
  end

  // Datapath: capture on start, shift one bit per RUN edge, publish on the last
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh      <= '0;
      b_sh      <= '0;
      r_sh      <= '0;
      cin       <= 1'b0;
      cnt       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sh <= op_a;
            b_sh <= b_cap;
            r_sh <= '0;
            cin  <= cin_cap;
            cnt  <= '0;
          end
        end
        S_RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          r_sh <= {sum, r_sh[WIDTH-1:1]};
          cin  <= cout;
          if (last) begin
            // result stays frozen during RUN; only the completed sum lands here
            result    <= {sum, r_sh[WIDTH-1:1]};
            carry_out <= cout;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl (WIDTH=8): timeline-level model plus directed ops.
// Subtract vectors run when SERIAL_ADD_SUB_EN is defined.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] op_a = '0, op_b = '0;
  logic         busy, done, carry_out;
  logic [W-1:0] result;

  int checks = 0;
  int errors = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub),
`endif
    .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result(result), .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  // Model: edge count k, edge index of last accepted start, arithmetic sum.
  // Busy spans W cycles after the accepting edge, done the one after that,
  // and a new op is accepted W+2 edges after the previous one.
  int         k = 0;
  int         acc = -100;
  logic [W:0] pend = '0;
  logic [W-1:0] m_res = '0;
  logic       m_co = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      k     <= 0;
      acc   <= -100;
      m_res <= '0;
      m_co  <= 1'b0;
    end else begin
      k <= k + 1;
      if (start && k >= acc + W + 2) begin
        acc <= k;
`ifdef SERIAL_ADD_SUB_EN
        pend <= sub ? ({1'b0, op_a} + {1'b0, ~op_b} + 1) : ({1'b0, op_a} + {1'b0, op_b});
`else
        pend <= {1'b0, op_a} + {1'b0, op_b};
`endif
      end
      if (k == acc + W) begin
        m_res <= pend[W-1:0];
        m_co  <= pend[W];
      end
    end
  end

  // Per-cycle compare of all outputs against the model
  always @(negedge clk) begin
    logic e_busy, e_done;
    e_busy = !rst && (k >= acc + 1) && (k <= acc + W);
    e_done = !rst && (k == acc + W + 1);
    checks++;
    if (busy !== e_busy || done !== e_done || result !== m_res || carry_out !== m_co) begin
      errors++;
      $display("FAIL model t=%0t got busy=%b done=%b res=%h co=%b want busy=%b done=%b res=%h co=%b",
               $time, busy, done, result, carry_out, e_busy, e_done, m_res, m_co);
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, got, exp);
    end
  endtask

  // One operation: checks latency, busy length, held result, final values.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [W-1:0] er, input logic ec, input string nm);
    int lat, busyc;
    logic [W-1:0] prev;
    prev = result;
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b; sub = s;
    @(negedge clk);
    start = 1'b0;
    lat = 0; busyc = 0;
    while (!done && lat < 40) begin
      if (busy) busyc++;
      if (lat == W - 1) chk({nm, "_held"}, 32'(result), 32'(prev));
      @(negedge clk);
      lat++;
    end
    chk({nm, "_lat"}, 32'(lat), 32'(W));
    chk({nm, "_busy"}, 32'(busyc), 32'(W));
    chk({nm, "_res"}, 32'(result), 32'(er));
    chk({nm, "_co"}, 32'(carry_out), 32'(ec));
    @(negedge clk);
    chk({nm, "_donefall"}, 32'(done), 32'(0));
  endtask

  initial begin
    int n, gap, dcnt;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_res", 32'(result), 32'(0));
    chk("rst_co", 32'(carry_out), 32'(0));
    rst = 1'b0;
    @(negedge clk);

    run_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "zero");
    run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, "add46");
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ovf");

    // start held high through busy: second op launched W+2 after the first
    @(negedge clk);
    start = 1'b1; op_a = 8'hA5; op_b = 8'h5A; sub = 1'b0;
    @(negedge clk);
    op_a = 8'h11; op_b = 8'h22;
    n = 0;
    while (!done && n < 40) begin @(negedge clk); n++; end
    chk("held_first_res", 32'(result), 32'hFF);
    chk("held_first_co", 32'(carry_out), 32'(0));
    @(negedge clk);
    gap = 1;
    while (!done && gap < 40) begin @(negedge clk); gap++; end
    start = 1'b0;
    chk("held_gap", 32'(gap), 32'(W + 2));
    chk("held_second_res", 32'(result), 32'h33);
    repeat (2) @(negedge clk);

    // reset during RUN after the 4th RUN edge
    start = 1'b1; op_a = 8'hF0; op_b = 8'h0F;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_done", 32'(done), 32'(0));
    chk("midrst_res", 32'(result), 32'(0));
    chk("midrst_co", 32'(carry_out), 32'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    dcnt = 0;
    repeat (W + 4) begin @(negedge clk); if (done) dcnt++; end
    chk("midrst_nodone", 32'(dcnt), 32'(0));
    run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "after_rst");

`ifdef SERIAL_ADD_SUB_EN
    run_op(8'h07, 8'h05, 1'b1, 8'h02, 1'b1, "sub_pos");
    run_op(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, "sub_neg");
    run_op(8'h05, 8'h07, 1'b0, 8'h0C, 1'b0, "sub_off");
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
